// File: rtl/cpu_pkg.sv
// Shared CPU-side types: arbiter FSM states, memory-port requester ids and
// the default memory read latency.
package cpu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } arb_state_e;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } port_id_e;

   localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. On a conflict the port not granted last
// wins; the last-grant register only moves when the caller accepts.
module rr_arb2
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_fetch_i,
   input  logic req_data_i,
   input  logic accept_i,
   output logic winner_o,
   output logic any_valid_o
);

   port_id_e last_q, last_d;
   port_id_e winner;

   always_comb begin
      winner = FETCH;
      if (req_fetch_i && req_data_i) begin
         winner = (last_q == FETCH) ? DATA : FETCH;
      end else if (req_data_i) begin
         winner = DATA;
      end
      last_d = accept_i ? winner : last_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= FETCH;
      end else begin
         last_q <= last_d;
      end
   end

   assign winner_o    = winner;
   assign any_valid_o = req_fetch_i | req_data_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the fetch and data ports,
// with a single outstanding transaction at a time.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_valid,
   input  logic [63:0] if_addr,
   output logic        if_ready,
   output logic        if_rvalid,
   output logic [63:0] if_rdata,
   input  logic        d_valid,
   input  logic        d_write,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_ready,
   output logic        d_rvalid,
   output logic [63:0] d_rdata,
   output logic        m_en,
   output logic        m_write,
   output logic [63:0] m_addr,
   output logic [63:0] m_wdata,
   input  logic [63:0] m_rdata
);

   arb_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   port_id_e   owner_q, owner_d;
   logic       wr_q, wr_d;

   logic       winner_raw;
   logic       any_valid;
   port_id_e   win;
   logic       accept;
   logic       resp;

   rr_arb2 u_rr_arb2 (
      .clk         (clk),
      .reset       (reset),
      .req_fetch_i (if_valid),
      .req_data_i  (d_valid),
      .accept_i    (accept),
      .winner_o    (winner_raw),
      .any_valid_o (any_valid)
   );

   assign win = port_id_e'(winner_raw);

   // Outputs are gated by reset so nothing leaks out while it is held.
   assign accept = (state_q == IDLE) && any_valid && !reset;
   assign resp   = (state_q == WAIT) && (cnt_q <= 4'd1) && !reset;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = WAIT;
               cnt_d   = 4'(MEM_LAT);
               owner_d = win;
               wr_d    = (win == DATA) && d_write;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         owner_q <= FETCH;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
      end
   end

   assign if_ready = accept && (win == FETCH);
   assign d_ready  = accept && (win == DATA);
   assign m_en     = accept;
   assign m_write  = accept && (win == DATA) && d_write;
   assign m_addr   = !accept ? 64'h0 : ((win == DATA) ? d_addr : if_addr);
   assign m_wdata  = (accept && (win == DATA)) ? d_wdata : 64'h0;

   // Stores are acked with zero data rather than whatever memory returns.
   assign if_rvalid = resp && (owner_q == FETCH);
   assign d_rvalid  = resp && (owner_q == DATA);
   assign if_rdata  = (if_rvalid && !wr_q) ? m_rdata : 64'h0;
   assign d_rdata   = (d_rvalid && !wr_q) ? m_rdata : 64'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a cycle-numbered transaction model; a second MEM_LAT=1 instance.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        if_valid, if_ready, if_rvalid;
   logic [63:0] if_addr, if_rdata;
   logic        d_valid, d_write, d_ready, d_rvalid;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic        m_en, m_write;
   logic [63:0] m_addr, m_wdata, m_rdata;

   logic        if_valid1, if_ready1, if_rvalid1;
   logic [63:0] if_addr1, if_rdata1;
   logic        d_valid1, d_write1, d_ready1, d_rvalid1;
   logic [63:0] d_addr1, d_wdata1, d_rdata1;
   logic        m_en1, m_write1;
   logic [63:0] m_addr1, m_wdata1, m_rdata1;

   mem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_valid(d_valid), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   mem_port_arbiter #(.MEM_LAT(1)) u_dut_lat1 (
      .clk(clk), .reset(reset),
      .if_valid(if_valid1), .if_addr(if_addr1), .if_ready(if_ready1),
      .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
      .d_valid(d_valid1), .d_write(d_write1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_ready(d_ready1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
      .m_en(m_en1), .m_write(m_write1), .m_addr(m_addr1), .m_wdata(m_wdata1),
      .m_rdata(m_rdata1)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Transaction model: a granted request completes at accept cycle + LAT,
   // and the port is free again from the following cycle.
   bit m_busy = 1'b0;
   int m_resp = 0;
   bit m_port = 1'b0;
   bit m_wr   = 1'b0;
   bit m_last = 1'b0;
   int cyc    = 0;
   bit acc_f, acc_d;

   logic        o_ir, o_dr, o_en, o_wr, o_irv, o_drv;
   logic [63:0] o_addr, o_wd, o_ird, o_drd;

   task automatic step(input bit rst_v, input bit iv, input logic [63:0] ia,
                       input bit dv, input bit dw, input logic [63:0] da,
                       input logic [63:0] dwd, input logic [63:0] rd);
      logic        e_ir, e_dr, e_en, e_wr, e_irv, e_drv;
      logic [63:0] e_addr, e_wd, e_ird, e_drd;
      bit          w;
      reset = rst_v; if_valid = iv; if_addr = ia;
      d_valid = dv; d_write = dw; d_addr = da; d_wdata = dwd; m_rdata = rd;
      @(negedge clk);
      o_ir = if_ready; o_dr = d_ready; o_en = m_en; o_wr = m_write;
      o_irv = if_rvalid; o_drv = d_rvalid; o_addr = m_addr; o_wd = m_wdata;
      o_ird = if_rdata; o_drd = d_rdata;
      e_ir = 0; e_dr = 0; e_en = 0; e_wr = 0; e_irv = 0; e_drv = 0;
      e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0; w = 0;
      acc_f = 0; acc_d = 0;
      if (!rst_v) begin
         if (!m_busy) begin
            if (iv || dv) begin
               w = (iv && dv) ? !m_last : dv;
               e_en = 1; e_ir = !w; e_dr = w; e_wr = w && dw;
               e_addr = w ? da : ia;
               e_wd = w ? dwd : 64'h0;
            end
         end else if (cyc == m_resp) begin
            if (m_port) begin e_drv = 1; e_drd = m_wr ? 64'h0 : rd; end
            else begin e_irv = 1; e_ird = rd; end
         end
      end
      chk("if_ready", 64'(o_ir), 64'(e_ir));
      chk("d_ready", 64'(o_dr), 64'(e_dr));
      chk("m_en", 64'(o_en), 64'(e_en));
      chk("if_rvalid", 64'(o_irv), 64'(e_irv));
      chk("d_rvalid", 64'(o_drv), 64'(e_drv));
      chk("if_rdata", o_ird, e_ird);
      chk("d_rdata", o_drd, e_drd);
      if (e_en || rst_v) begin
         chk("m_write", 64'(o_wr), 64'(e_wr));
         chk("m_addr", o_addr, e_addr);
         chk("m_wdata", o_wd, e_wd);
      end
      if (rst_v) begin
         m_busy = 0; m_last = 0;
      end else if (!m_busy && e_en) begin
         m_busy = 1; m_resp = cyc + LAT; m_port = w; m_wr = w && dw; m_last = w;
         acc_f = !w; acc_d = w;
      end else if (m_busy && cyc == m_resp) begin
         m_busy = 0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [63:0] rd);
      step(0, 0, 64'h0, 0, 0, 64'h0, 64'h0, rd);
   endtask

   initial begin
      bit          pi, pd, dw, r;
      logic [63:0] ia, da, dwd;
      reset = 1; if_valid = 0; if_addr = 0; d_valid = 0; d_write = 0;
      d_addr = 0; d_wdata = 0; m_rdata = 0;
      if_valid1 = 0; if_addr1 = 0; d_valid1 = 0; d_write1 = 0;
      d_addr1 = 0; d_wdata1 = 0; m_rdata1 = 0;

      // Reset with requests present: everything must stay quiet.
      step(1, 1, 64'h40, 1, 1, 64'h80, 64'h11, 64'hFFFF);
      step(1, 0, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0);

      // Fetch-only read.
      step(0, 1, 64'h40, 0, 0, 64'h0, 64'h0, 64'h0);
      chk("rd_ready", 64'(o_ir), 64'h1);
      chk("rd_maddr", o_addr, 64'h40);
      idle(64'h0);
      chk("rd_early", 64'(o_irv), 64'h0);
      idle(64'hDEAD);
      chk("rd_rvalid", 64'(o_irv), 64'h1);
      chk("rd_rdata", o_ird, 64'hDEAD);
      idle(64'hBEEF);
      chk("rd_late", 64'(o_irv), 64'h0);

      // Conflict straight after reset: data first, fetch three cycles later.
      step(1, 0, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0);
      step(0, 1, 64'h8, 1, 0, 64'h100, 64'h0, 64'h0);
      chk("cf_d_first", 64'(o_dr), 64'h1);
      chk("cf_addr0", o_addr, 64'h100);
      step(0, 1, 64'h8, 0, 0, 64'h0, 64'h0, 64'h0);
      step(0, 1, 64'h8, 0, 0, 64'h0, 64'h0, 64'h1234);
      step(0, 1, 64'h8, 0, 0, 64'h0, 64'h0, 64'h0);
      chk("cf_f_next", 64'(o_ir), 64'h1);
      chk("cf_addr1", o_addr, 64'h8);
      idle(64'h0); idle(64'h5678);

      // Store acked with zero data.
      step(0, 0, 64'h0, 1, 1, 64'h20, 64'h55, 64'h0);
      chk("st_write", 64'(o_wr), 64'h1);
      chk("st_wdata", o_wd, 64'h55);
      idle(64'h0);
      idle(64'hCAFE);
      chk("st_ack", 64'(o_drv), 64'h1);
      chk("st_rdata", o_drd, 64'h0);

      // Sustained conflict: alternating grants every LAT+1 cycles.
      step(1, 0, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0);
      for (int k = 0; k < 18; k++) begin
         step(0, 1, 64'h1000, 1, 0, 64'h2000, 64'h0, 64'(k));
         if (k % 3 == 0) begin
            chk("alt_d", 64'(o_dr), 64'(((k / 3) % 2) == 0));
            chk("alt_f", 64'(o_ir), 64'(((k / 3) % 2) == 1));
         end else begin
            chk("alt_gap", 64'(o_ir | o_dr), 64'h0);
         end
      end

      // Reset in the middle of a read aborts it.
      step(1, 0, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0);
      step(0, 1, 64'h300, 0, 0, 64'h0, 64'h0, 64'h0);
      step(1, 1, 64'h300, 0, 0, 64'h0, 64'h0, 64'h77);
      step(0, 1, 64'h300, 0, 0, 64'h0, 64'h0, 64'h99);
      chk("ab_no_rvalid", 64'(o_irv), 64'h0);
      chk("ab_reaccept", 64'(o_ir), 64'h1);
      idle(64'h0); idle(64'h0); idle(64'h0);

      // Random traffic against the model.
      pi = 0; pd = 0; dw = 0; ia = 0; da = 0; dwd = 0;
      for (int i = 0; i < 600; i++) begin
         if (!pi && ($urandom % 2 == 1)) begin pi = 1; ia = {$urandom, $urandom}; end
         if (!pd && ($urandom % 2 == 1)) begin
            pd = 1; da = {$urandom, $urandom}; dwd = {$urandom, $urandom};
            dw = ($urandom % 2 == 1);
         end
         if (pi && ($urandom % 16 == 0)) pi = 0;
         if (pd && ($urandom % 16 == 0)) pd = 0;
         r = ($urandom % 50 == 0);
         step(r, pi, ia, pd, dw, da, dwd, {$urandom, $urandom});
         if (acc_f) pi = 0;
         if (acc_d) pd = 0;
      end
      idle(64'h0); idle(64'h0); idle(64'h0);

      // MEM_LAT=1 instance: back-to-back fetches every other cycle.
      for (int k = 0; k < 6; k++) begin
         if_valid1 = 1; if_addr1 = 64'(k); m_rdata1 = {$urandom, $urandom};
         @(negedge clk);
         chk("l1_ready", 64'(if_ready1), 64'(k % 2 == 0));
         chk("l1_rvalid", 64'(if_rvalid1), 64'(k % 2 == 1));
         chk("l1_rdata", if_rdata1, (k % 2 == 1) ? m_rdata1 : 64'h0);
         @(posedge clk);
         #1;
      end
      if_valid1 = 0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
